// File: rtl/uart_loader_pkg.sv
// Shared types for the UART instruction-memory boot loader.
// Optional checksum trailer is enabled by UART_IMEM_LOADER_CHECKSUM_EN.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      SYNC,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT
   } rx_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Little-endian byte placement into a 32-bit instruction word.
   function automatic logic [31:0] put_lane(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      res[lane*8 +: 8] = data;
      return res;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchronizer, mid-bit sampling and
// start-glitch rejection; emits one-cycle byte_valid / frame_err pulses.
module uart_rx
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_q1;
   logic          rx_s;
   logic          rx_d;
   rx_state_t     st;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_q1      <= 1'b1;
         rx_s       <= 1'b1;
         rx_d       <= 1'b1;
         st         <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         rx_q1      <= rx;
         rx_s       <= rx_q1;
         rx_d       <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (st)
            RX_IDLE: begin
               if (rx_d && !rx_s) begin
                  cnt <= '0;
                  st  <= RX_START;
               end
            end
            RX_START: begin
               // Line back high at mid start bit means it was only a glitch.
               if (cnt == HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  st      <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == FULL) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) st <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == FULL) begin
                  cnt <= '0;
                  if (rx_s) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                     st         <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     st        <= RX_WAIT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_WAIT: begin
               // A held-low line must not be mistaken for a new start bit.
               if (rx_s) st <= RX_IDLE;
            end
            default: st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives A5 / len_lo / len_hi / N LE words over UART, writes imem,
// holds core_rst until done. UART_IMEM_LOADER_CHECKSUM_EN adds a sum-mod-256 trailer.
module uart_imem_loader
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int IMEM_WORDS   = 1024,
   parameter int ADDR_W       = $clog2(IMEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_err,
   output logic              frame_err
);

   localparam int          CW    = ADDR_W + 1;
   localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

   logic          byte_valid;
   logic [7:0]    byte_data;
   loader_state_t state;
   logic [7:0]    len_lo;
   logic [CW-1:0] n_words;
   logic [CW-1:0] wcnt;
   logic [1:0]    byte_idx;
   logic [31:0]   asm_word;
   logic [15:0]   n_full;
   logic [CW-1:0] wcnt_nx;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif

   assign n_full  = {byte_data, len_lo};
   assign wcnt_nx = wcnt + 1'b1;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= SYNC;
         len_lo     <= '0;
         n_words    <= '0;
         wcnt       <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_rst   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            SYNC: begin
               if (byte_valid && byte_data == SYNC_BYTE) state <= LEN_LO;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
               csum <= '0;
`endif
            end
            LEN_LO: begin
               if (byte_valid) begin
                  len_lo <= byte_data;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (byte_valid) begin
                  if ({1'b0, n_full} > MAX_N) begin
                     load_err <= 1'b1;
                     state    <= ERROR;
                  end else if (n_full == 16'd0) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                     state <= CHECK;
`else
                     core_rst  <= 1'b0;
                     load_done <= 1'b1;
                     state     <= DONE;
`endif
                  end else begin
                     n_words  <= CW'(n_full);
                     wcnt     <= '0;
                     byte_idx <= '0;
                     state    <= DATA;
                  end
               end
            end
            DATA: begin
               if (byte_valid) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                  csum <= csum + byte_data;
`endif
                  asm_word <= put_lane(asm_word, byte_idx, byte_data);
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= wcnt[ADDR_W-1:0];
                     imem_wdata <= put_lane(asm_word, 2'd3, byte_data);
                     wcnt       <= wcnt_nx;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                     if (wcnt_nx == n_words) state <= CHECK;
`else
                     if (wcnt_nx == n_words) state <= DONE;
`endif
                  end
               end
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (byte_valid) begin
                  if (byte_data == csum) begin
                     core_rst  <= 1'b0;
                     load_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     load_err <= 1'b1;
                     state    <= ERROR;
                  end
               end
            end
`endif
            DONE: begin
               core_rst  <= 1'b0;
               load_done <= 1'b1;
               // A fresh sync byte reloads the image with the core held again.
               if (byte_valid && byte_data == SYNC_BYTE) begin
                  core_rst  <= 1'b1;
                  load_done <= 1'b0;
                  state     <= LEN_LO;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end
            ERROR: begin
               core_rst <= 1'b1;
               load_err <= 1'b1;
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed protocol cases plus randomized image loads
// checked against a word-list model; honours UART_IMEM_LOADER_CHECKSUM_EN.
module tb_uart_imem_loader;

   localparam int CPB    = 8;
   localparam int WORDS  = 16;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst;
   logic              rx;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              load_done;
   logic              load_err;
   logic              frame_err;

   int checks = 0;
   int errors = 0;

   // Monitor state (written only by the monitor process)
   int          cyc = 0;
   int          last_we_cyc = -1;
   int          fall_cyc = -1;
   int          fe_cnt = 0;
   logic        prev_crst = 1'b1;
   logic [3:0]  wq_addr[$];
   logic [31:0] wq_data[$];

   // Reference model: words expected in memory and bytes to transmit
   logic [31:0] mdl[$];
   logic [7:0]  txq[$];

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .core_rst  (core_rst),
      .load_done (load_done),
      .load_err  (load_err),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (imem_we === 1'b1) begin
         wq_addr.push_back(imem_addr);
         wq_data.push_back(imem_wdata);
         last_we_cyc = cyc;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (prev_crst === 1'b1 && core_rst === 1'b0) fall_cyc = cyc;
      prev_crst = core_rst;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      tick(stop ? 4 : CPB + 4);
   endtask

   task automatic flush_tx();
      while (txq.size() > 0) send_byte(txq.pop_front(), 1'b1);
   endtask

   // Payload bytes of mdl little-endian, plus the trailer when enabled
   task automatic queue_payload();
      logic [7:0] sum;
      sum = 8'h00;
      foreach (mdl[i]) begin
         for (int k = 0; k < 4; k++) begin
            txq.push_back(mdl[i][8*k +: 8]);
            sum = sum + mdl[i][8*k +: 8];
         end
      end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      txq.push_back(sum);
`endif
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      rx  = 1'b1;
      tick(3);
      chk({tag, "_core_rst"}, {31'b0, core_rst}, 32'd1);
      chk({tag, "_we"}, {31'b0, imem_we}, 32'd0);
      chk({tag, "_done"}, {31'b0, load_done}, 32'd0);
      chk({tag, "_err"}, {31'b0, load_err}, 32'd0);
      rst = 1'b1;
      tick(2);
   endtask

   task automatic check_writes(input string tag, input int base);
      chk({tag, "_nwr"}, wq_addr.size() - base, mdl.size());
      for (int i = 0; i < mdl.size() && base + i < wq_addr.size(); i++) begin
         chk({tag, "_addr"}, {28'b0, wq_addr[base+i]}, i);
         chk({tag, "_data"}, wq_data[base+i], mdl[i]);
      end
   endtask

   initial begin
      int base;
      int fe0;
      int n;
      rst = 1'b0;
      rx  = 1'b1;

      do_reset("rst");
      chk("rst_addr", {28'b0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_ferr", {31'b0, frame_err}, 32'd0);

      // Two-word directed image
      base = wq_addr.size();
      mdl = {32'h0000_0013, 32'h0020_00B3};
      txq = {8'hA5, 8'h02, 8'h00};
      queue_payload();
      flush_tx();
      tick(6);
      check_writes("img2", base);
      chk("img2_done", {31'b0, load_done}, 32'd1);
      chk("img2_core_rst", {31'b0, core_rst}, 32'd0);
`ifndef UART_IMEM_LOADER_CHECKSUM_EN
      chk("img2_rel_lat", fall_cyc - last_we_cyc, 32'd1);
`endif

      // Junk before sync, zero-length image
      do_reset("rst2");
      base = wq_addr.size();
      mdl.delete();
      txq = {8'h55, 8'hA5, 8'h00, 8'h00};
      queue_payload();
      flush_tx();
      tick(6);
      chk("zero_nwr", wq_addr.size() - base, 32'd0);
      chk("zero_done", {31'b0, load_done}, 32'd1);
      chk("zero_core_rst", {31'b0, core_rst}, 32'd0);

      // Bad stop bit while DONE: one pulse, state kept
      fe0 = fe_cnt;
      send_byte(8'h3C, 1'b0);
      tick(4);
      chk("fe_pulses", fe_cnt - fe0, 32'd1);
      chk("fe_done_kept", {31'b0, load_done}, 32'd1);
      chk("fe_core_rst", {31'b0, core_rst}, 32'd0);

      // Bad stop bit and a start glitch in LEN_LO must not consume a length byte
      do_reset("rst3");
      fe0 = fe_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h07, 1'b0);
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(3 * CPB);
      mdl.delete();
      txq = {8'h00, 8'h00};
      queue_payload();
      flush_tx();
      tick(6);
      chk("glitch_fe", fe_cnt - fe0, 32'd1);
      chk("glitch_done", {31'b0, load_done}, 32'd1);
      chk("glitch_err", {31'b0, load_err}, 32'd0);

      // Oversized length is terminal until reset
      do_reset("rst4");
      base = wq_addr.size();
      txq = {8'hA5, 8'h11, 8'h00};
      flush_tx();
      tick(4);
      chk("big_err", {31'b0, load_err}, 32'd1);
      chk("big_core_rst", {31'b0, core_rst}, 32'd1);
      txq = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      flush_tx();
      tick(4);
      chk("big_sticky_err", {31'b0, load_err}, 32'd1);
      chk("big_sticky_done", {31'b0, load_done}, 32'd0);
      chk("big_nwr", wq_addr.size() - base, 32'd0);

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      do_reset("rst_cs");
      txq = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      flush_tx();
      tick(4);
      chk("cs_ok_done", {31'b0, load_done}, 32'd1);
      chk("cs_ok_err", {31'b0, load_err}, 32'd0);
      do_reset("rst_cs2");
      txq = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
      flush_tx();
      tick(4);
      chk("cs_bad_err", {31'b0, load_err}, 32'd1);
      chk("cs_bad_core_rst", {31'b0, core_rst}, 32'd1);
`endif

      // Reset in the middle of a word abandons the load
      do_reset("rst5");
      txq = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
      flush_tx();
      rst = 1'b0;
      tick(2);
      chk("mid_core_rst", {31'b0, core_rst}, 32'd1);
      chk("mid_done", {31'b0, load_done}, 32'd0);
      rst = 1'b1;
      tick(2);
      mdl.delete();
      txq = {8'hA5, 8'h00, 8'h00};
      queue_payload();
      flush_tx();
      tick(4);
      chk("mid_resync_done", {31'b0, load_done}, 32'd1);

      // Randomized loads; later ones reload from DONE. First uses full depth.
      do_reset("rst6");
      for (int t = 0; t < 5; t++) begin
         n = (t == 0) ? WORDS : int'($urandom_range(1, WORDS));
         mdl.delete();
         for (int i = 0; i < n; i++) mdl.push_back($urandom);
         base = wq_addr.size();
         send_byte(8'hA5, 1'b1);
         chk("rnd_hold_core", {31'b0, core_rst}, 32'd1);
         chk("rnd_hold_done", {31'b0, load_done}, 32'd0);
         txq = {n[7:0], n[15:8]};
         queue_payload();
         flush_tx();
         tick(6);
         check_writes("rnd", base);
         chk("rnd_done", {31'b0, load_done}, 32'd1);
         chk("rnd_core_rst", {31'b0, core_rst}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
